b_predictor: RTL and testbench

Gshare branch direction predictor that sits directly upstream of the branch unit. At branch issue it supplies the taken/not-taken prediction, the table index (pattern) and the recovery address that the branch unit stores per entry. At branch commit it consumes the branch unit's failure flag and returned pattern to train its counter table and its committed global history. On a pipeline flush it restores the speculative history from the committed history.

---
 rtl/b_predictor.sv | 123 ++++++++++++
 tb/tb_b_predictor.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/b_predictor.sv
// Gshare branch direction predictor: speculative lookup at issue, counter and
// history training at commit, speculative history recovery on flush.
`timescale 1ns/1ps
module b_predictor #(
    parameter int unsigned PATTERN_WIDTH  = 8,
    parameter int unsigned INST_MEM_WIDTH = 14,
    parameter int unsigned N_B_ENTRY      = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          issue,
    input  logic [INST_MEM_WIDTH-1:0]     pc,
    input  logic [INST_MEM_WIDTH-1:0]     target,
    output logic                          prediction,
    output logic [PATTERN_WIDTH-1:0]      pattern_out,
    output logic [INST_MEM_WIDTH-1:0]     addr_on_failure,
    output logic [INST_MEM_WIDTH-1:0]     predicted_addr,
    input  logic                          commit,
    input  logic                          commit_failure,
    input  logic [PATTERN_WIDTH-1:0]      commit_pattern,
    input  logic                          flush,
    output logic [$clog2(N_B_ENTRY):0]    in_flight
);

    localparam int unsigned N_CTR = 2 ** PATTERN_WIDTH;
    localparam int unsigned PTR_W = (N_B_ENTRY > 1) ? $clog2(N_B_ENTRY) : 1;
    localparam int unsigned CNT_W = $clog2(N_B_ENTRY) + 1;

    logic [1:0]                ctr [N_CTR];
    logic [PATTERN_WIDTH-1:0]  spec_ghr;
    logic [PATTERN_WIDTH-1:0]  com_ghr;
    logic [PATTERN_WIDTH-1:0]  com_ghr_nxt;
    logic [PATTERN_WIDTH-1:0]  idx;
    logic [N_B_ENTRY-1:0]      pred_q;
    logic [PTR_W-1:0]          head;
    logic [PTR_W-1:0]          tail;
    logic [CNT_W-1:0]          count;
    logic [INST_MEM_WIDTH-1:0] pc_inc;
    logic                      full;
    logic                      commit_ok;
    logic                      push;
    logic                      taken;
    logic [1:0]                ctr_cur;
    logic [1:0]                ctr_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N_B_ENTRY - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Zero-latency lookup from the current pc and speculative history
    assign idx             = pc[PATTERN_WIDTH-1:0] ^ spec_ghr;
    assign prediction      = ctr[idx][1];
    assign pattern_out     = idx;
    assign pc_inc          = pc + INST_MEM_WIDTH'(1);
    assign addr_on_failure = prediction ? pc_inc : target;
    assign predicted_addr  = prediction ? target : pc_inc;
    assign in_flight       = count;

    always_comb begin
        full        = (count == CNT_W'(N_B_ENTRY));
        commit_ok   = commit && (count != '0);
        // A full FIFO still accepts a push when the same-cycle pop frees a slot
        push        = issue && !flush && (!full || commit_ok);
        taken       = pred_q[head] ^ commit_failure;
        com_ghr_nxt = commit_ok ? {com_ghr[PATTERN_WIDTH-2:0], taken} : com_ghr;
        ctr_cur     = ctr[commit_pattern];
        ctr_nxt     = ctr_cur;
        if (taken && ctr_cur != 2'b11) begin
            ctr_nxt = ctr_cur + 2'b01;
        end else if (!taken && ctr_cur != 2'b00) begin
            ctr_nxt = ctr_cur - 2'b01;
        end
    end

    // History registers and in-flight prediction FIFO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spec_ghr <= '0;
            com_ghr  <= '0;
            pred_q   <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            com_ghr <= com_ghr_nxt;
            if (flush) begin
                spec_ghr <= com_ghr_nxt;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
            end else begin
                if (issue) begin
                    spec_ghr <= {spec_ghr[PATTERN_WIDTH-2:0], prediction};
                end
                if (push) begin
                    pred_q[tail] <= prediction;
                    tail         <= ptr_inc(tail);
                end
                if (commit_ok) begin
                    head <= ptr_inc(head);
                end
                count <= count + CNT_W'(push) - CNT_W'(commit_ok);
            end
        end
    end

    // Pattern table of 2-bit saturating counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_CTR; i++) begin
                ctr[i] <= 2'b01;
            end
        end else if (commit_ok) begin
            ctr[commit_pattern] <= ctr_nxt;
        end
    end

    a_commit_empty: assert property (@(posedge clk) disable iff (reset)
        !(commit && count == '0));
    a_issue_full: assert property (@(posedge clk) disable iff (reset)
        !(issue && !flush && !commit && full));

endmodule

// File: tb/tb_b_predictor.sv
// Directed self-checking bench for the gshare predictor.
`timescale 1ns/1ps
module tb_b_predictor;

    logic        clk;
    logic        reset;
    logic        issue;
    logic [13:0] pc;
    logic [13:0] target;
    logic        prediction;
    logic [7:0]  pattern_out;
    logic [13:0] addr_on_failure;
    logic [13:0] predicted_addr;
    logic        commit;
    logic        commit_failure;
    logic [7:0]  commit_pattern;
    logic        flush;
    logic [2:0]  in_flight;

    int checks;
    int failures;

    b_predictor dut (
        .clk            (clk),
        .reset          (reset),
        .issue          (issue),
        .pc             (pc),
        .target         (target),
        .prediction     (prediction),
        .pattern_out    (pattern_out),
        .addr_on_failure(addr_on_failure),
        .predicted_addr (predicted_addr),
        .commit         (commit),
        .commit_failure (commit_failure),
        .commit_pattern (commit_pattern),
        .flush          (flush),
        .in_flight      (in_flight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic i, input logic [13:0] p, input logic c,
                         input logic f, input logic [7:0] pat, input logic fl);
        issue          = i;
        pc             = p;
        commit         = c;
        commit_failure = f;
        commit_pattern = pat;
        flush          = fl;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        issue          = 1'b0;
        commit         = 1'b0;
        commit_failure = 1'b0;
        flush          = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        drive(1'b0, 14'h000, 1'b0, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset  = 1'b1;
        pc     = 14'h010;
        target = 14'h100;
        #1;
        checks++; if (prediction !== 1'b0) begin failures++; $display("FAIL reset_pred got=%0h exp=0", prediction); end
        checks++; if (pattern_out !== 8'h10) begin failures++; $display("FAIL reset_pattern got=%0h exp=10", pattern_out); end
        checks++; if (addr_on_failure !== 14'h100) begin failures++; $display("FAIL reset_aof got=%0h exp=100", addr_on_failure); end
        checks++; if (predicted_addr !== 14'h011) begin failures++; $display("FAIL reset_paddr got=%0h exp=11", predicted_addr); end
        checks++; if (in_flight !== 3'd0) begin failures++; $display("FAIL reset_inflight got=%0d exp=0", in_flight); end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_training;
        do_reset;
        target = 14'h200;
        drive(1'b1, 14'h005, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        checks++; if (prediction !== 1'b0) begin failures++; $display("FAIL train_pre got=%0h exp=0", prediction); end
        tick;
        checks++; if (in_flight !== 3'd1) begin failures++; $display("FAIL train_inflight1 got=%0d exp=1", in_flight); end
        drive(1'b0, 14'h005, 1'b1, 1'b1, 8'h05, 1'b0);
        tick;
        drive(1'b0, 14'h005, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        checks++; if (prediction !== 1'b1) begin failures++; $display("FAIL train_post got=%0h exp=1", prediction); end
        checks++; if (predicted_addr !== 14'h200) begin failures++; $display("FAIL train_paddr got=%0h exp=200", predicted_addr); end
        checks++; if (addr_on_failure !== 14'h006) begin failures++; $display("FAIL train_aof got=%0h exp=6", addr_on_failure); end
        checks++; if (in_flight !== 3'd0) begin failures++; $display("FAIL train_inflight0 got=%0d exp=0", in_flight); end
    endtask

    // Filler branches at pc 0x033 always predict not-taken, so failure=1 means taken
    task automatic test_saturation;
        do_reset;
        drive(1'b1, 14'h033, 1'b0, 1'b0, 8'h00, 1'b0);
        tick;
        repeat (5) begin drive(1'b1, 14'h033, 1'b1, 1'b1, 8'h05, 1'b0); tick; end
        drive(1'b0, 14'h005, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        checks++; if (prediction !== 1'b1) begin failures++; $display("FAIL sat_hi got=%0h exp=1", prediction); end
        drive(1'b1, 14'h033, 1'b1, 1'b0, 8'h05, 1'b0);
        tick;
        drive(1'b0, 14'h005, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        checks++; if (prediction !== 1'b1) begin failures++; $display("FAIL sat_hi_hold got=%0h exp=1", prediction); end
        repeat (4) begin drive(1'b1, 14'h033, 1'b1, 1'b0, 8'h05, 1'b0); tick; end
        drive(1'b0, 14'h005, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        checks++; if (prediction !== 1'b0) begin failures++; $display("FAIL sat_lo got=%0h exp=0", prediction); end
        drive(1'b1, 14'h033, 1'b1, 1'b1, 8'h05, 1'b0);
        tick;
        drive(1'b0, 14'h005, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        checks++; if (prediction !== 1'b0) begin failures++; $display("FAIL sat_lo_hold got=%0h exp=0", prediction); end
        drive(1'b0, 14'h033, 1'b1, 1'b1, 8'h05, 1'b0);
        tick;
        drive(1'b0, 14'h005, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        checks++; if (prediction !== 1'b1) begin failures++; $display("FAIL sat_recover got=%0h exp=1", prediction); end
        checks++; if (in_flight !== 3'd0) begin failures++; $display("FAIL sat_inflight got=%0d exp=0", in_flight); end
    endtask

    task automatic test_history;
        do_reset;
        drive(1'b1, 14'h033, 1'b0, 1'b0, 8'h00, 1'b0); tick;
        drive(1'b1, 14'h033, 1'b1, 1'b1, 8'h11, 1'b0); tick;
        drive(1'b0, 14'h033, 1'b1, 1'b1, 8'h22, 1'b0); tick;
        drive(1'b1, 14'h0A0, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        checks++; if (prediction !== 1'b0) begin failures++; $display("FAIL hist_p0 got=%0h exp=0", prediction); end
        tick;
        drive(1'b1, 14'h011, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        checks++; if (prediction !== 1'b1) begin failures++; $display("FAIL hist_p1 got=%0h exp=1", prediction); end
        tick;
        drive(1'b1, 14'h023, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        checks++; if (pattern_out !== 8'h22) begin failures++; $display("FAIL hist_idx2 got=%0h exp=22", pattern_out); end
        checks++; if (prediction !== 1'b1) begin failures++; $display("FAIL hist_p2 got=%0h exp=1", prediction); end
        tick;
        drive(1'b0, 14'h0F0, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        checks++; if (pattern_out !== 8'hF3) begin failures++; $display("FAIL hist_idx got=%0h exp=f3", pattern_out); end
        checks++; if (in_flight !== 3'd3) begin failures++; $display("FAIL hist_inflight got=%0d exp=3", in_flight); end
    endtask

    task automatic test_flush;
        do_reset;
        drive(1'b1, 14'h033, 1'b0, 1'b0, 8'h00, 1'b0); tick;
        drive(1'b1, 14'h033, 1'b1, 1'b1, 8'h80, 1'b0); tick;
        drive(1'b1, 14'h033, 1'b1, 1'b0, 8'h81, 1'b0); tick;
        drive(1'b1, 14'h080, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        checks++; if (prediction !== 1'b1) begin failures++; $display("FAIL flush_setup_p got=%0h exp=1", prediction); end
        tick;
        drive(1'b1, 14'h081, 1'b0, 1'b0, 8'h00, 1'b0); tick;
        drive(1'b1, 14'h083, 1'b0, 1'b0, 8'h00, 1'b0); tick;
        drive(1'b0, 14'h000, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        checks++; if (pattern_out !== 8'h07) begin failures++; $display("FAIL flush_spec_pre got=%0h exp=7", pattern_out); end
        checks++; if (in_flight !== 3'd4) begin failures++; $display("FAIL flush_inflight_pre got=%0d exp=4", in_flight); end
        drive(1'b1, 14'h087, 1'b1, 1'b1, 8'h90, 1'b1);
        tick;
        drive(1'b0, 14'h000, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        checks++; if (pattern_out !== 8'h05) begin failures++; $display("FAIL flush_spec_post got=%0h exp=5", pattern_out); end
        checks++; if (in_flight !== 3'd0) begin failures++; $display("FAIL flush_inflight_post got=%0d exp=0", in_flight); end
        drive(1'b0, 14'h095, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        checks++; if (prediction !== 1'b1) begin failures++; $display("FAIL flush_train got=%0h exp=1", prediction); end
    endtask

    task automatic test_full_boundary;
        do_reset;
        drive(1'b1, 14'h033, 1'b0, 1'b0, 8'h00, 1'b0); tick;
        drive(1'b0, 14'h033, 1'b1, 1'b1, 8'h80, 1'b0); tick;
        drive(1'b1, 14'h080, 1'b0, 1'b0, 8'h00, 1'b0); tick;
        drive(1'b1, 14'h033, 1'b0, 1'b0, 8'h00, 1'b0); tick;
        drive(1'b1, 14'h082, 1'b0, 1'b0, 8'h00, 1'b0); tick;
        drive(1'b1, 14'h033, 1'b0, 1'b0, 8'h00, 1'b0); tick;
        drive(1'b0, 14'h000, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        checks++; if (pattern_out !== 8'h0A) begin failures++; $display("FAIL full_spec got=%0h exp=a", pattern_out); end
        checks++; if (in_flight !== 3'd4) begin failures++; $display("FAIL full_inflight got=%0d exp=4", in_flight); end
        drive(1'b1, 14'h08A, 1'b1, 1'b0, 8'hC0, 1'b0);
        #1;
        checks++; if (prediction !== 1'b1) begin failures++; $display("FAIL full_new_p got=%0h exp=1", prediction); end
        tick;
        drive(1'b0, 14'h000, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        checks++; if (in_flight !== 3'd4) begin failures++; $display("FAIL full_inflight_hold got=%0d exp=4", in_flight); end
        checks++; if (pattern_out !== 8'h15) begin failures++; $display("FAIL full_spec_post got=%0h exp=15", pattern_out); end
        repeat (3) begin drive(1'b0, 14'h000, 1'b1, 1'b0, 8'hC0, 1'b0); tick; end
        checks++; if (in_flight !== 3'd1) begin failures++; $display("FAIL full_drain got=%0d exp=1", in_flight); end
        drive(1'b0, 14'h000, 1'b1, 1'b0, 8'hC0, 1'b1);
        tick;
        drive(1'b0, 14'h000, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        checks++; if (pattern_out !== 8'h35) begin failures++; $display("FAIL full_order got=%0h exp=35", pattern_out); end
        checks++; if (in_flight !== 3'd0) begin failures++; $display("FAIL full_empty got=%0d exp=0", in_flight); end
    endtask

    task automatic test_same_index;
        do_reset;
        drive(1'b1, 14'h033, 1'b0, 1'b0, 8'h00, 1'b0); tick;
        drive(1'b1, 14'h005, 1'b1, 1'b1, 8'h05, 1'b0);
        #1;
        checks++; if (prediction !== 1'b0) begin failures++; $display("FAIL same_pre got=%0h exp=0", prediction); end
        tick;
        drive(1'b0, 14'h005, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        checks++; if (prediction !== 1'b1) begin failures++; $display("FAIL same_post got=%0h exp=1", prediction); end
    endtask

    task automatic test_async_reset;
        do_reset;
        drive(1'b1, 14'h033, 1'b0, 1'b0, 8'h00, 1'b0); tick;
        drive(1'b1, 14'h033, 1'b0, 1'b0, 8'h00, 1'b0); tick;
        checks++; if (in_flight !== 3'd2) begin failures++; $display("FAIL async_pre got=%0d exp=2", in_flight); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (in_flight !== 3'd0) begin failures++; $display("FAIL async_clear got=%0d exp=0", in_flight); end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        target   = 14'h000;
        drive(1'b0, 14'h000, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        test_reset;
        test_training;
        test_saturation;
        test_history;
        test_flush;
        test_full_boundary;
        test_same_index;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
